// File: rtl/hazard_sched_if.sv
// Hazard scheduler signal bundle: decoder-side request fields in, forwarding/stall/MDU status out.
// The slave modport is the scheduler; the master modport is the pipeline control that feeds it.
interface hazard_sched_if;
    logic [4:0]  RSD, RTD, RSE, RTE;
    logic        BRANCHD, PCSRCD, JMPD, MDUSTARTD, MDUREADD;
    logic [4:0]  WRITEREGE, WRITEREGM, WRITEREGW;
    logic        WREGE, M2REGE, MDUSTARTE, WREGM, M2REGM, WREGW;
    logic        FORWARDAD, FORWARDBD;
    logic [1:0]  FORWARDAE, FORWARDBE;
    logic        STALLF, STALLD, FLUSHD, FLUSHE;
    logic        MDUBUSY, MDUDONE;
    logic [31:0] STALLCNT, FLUSHCNT;

    modport slave (
        input  RSD, RTD, RSE, RTE, BRANCHD, PCSRCD, JMPD, MDUSTARTD, MDUREADD,
               WRITEREGE, WRITEREGM, WRITEREGW, WREGE, M2REGE, MDUSTARTE,
               WREGM, M2REGM, WREGW,
        output FORWARDAD, FORWARDBD, FORWARDAE, FORWARDBE,
               STALLF, STALLD, FLUSHD, FLUSHE, MDUBUSY, MDUDONE,
               STALLCNT, FLUSHCNT
    );

    modport master (
        output RSD, RTD, RSE, RTE, BRANCHD, PCSRCD, JMPD, MDUSTARTD, MDUREADD,
               WRITEREGE, WRITEREGM, WRITEREGW, WREGE, M2REGE, MDUSTARTE,
               WREGM, M2REGM, WREGW,
        input  FORWARDAD, FORWARDBD, FORWARDAE, FORWARDBE,
               STALLF, STALLD, FLUSHD, FLUSHE, MDUBUSY, MDUDONE,
               STALLCNT, FLUSHCNT
    );
endinterface

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS core: forwarding selects, stalls/flushes, MDU busy sequencing.
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_sched #(
    parameter int MDU_LAT = 32
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_sched_if.slave hz
);
    typedef enum logic {S_IDLE, S_RUN} mdu_state_t;

    localparam logic [7:0] LAT8 = 8'(MDU_LAT);

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (src != 5'd0) && (dst == src);
    endfunction

    mdu_state_t r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       w_done;
    logic       w_busy;
    logic       w_lwstall, w_brstall, w_mdustall, w_stall, w_flushd;
    logic [31:0] w_stallcnt, w_flushcnt;

    assign w_busy = (r_state == S_RUN) && !RST;

    always_comb begin
        w_lwstall  = hz.M2REGE && (hit(hz.WREGE, hz.WRITEREGE, hz.RSD) ||
                                   hit(hz.WREGE, hz.WRITEREGE, hz.RTD));
        w_brstall  = hz.BRANCHD && (hit(hz.WREGE,  hz.WRITEREGE, hz.RSD) ||
                                    hit(hz.WREGE,  hz.WRITEREGE, hz.RTD) ||
                                    hit(hz.M2REGM, hz.WRITEREGM, hz.RSD) ||
                                    hit(hz.M2REGM, hz.WRITEREGM, hz.RTD));
        // Issue in E this cycle counts as occupied, catching back-to-back mult and mfhi right behind it.
        w_mdustall = (hz.MDUSTARTD || hz.MDUREADD) && (w_busy || hz.MDUSTARTE);
        w_stall    = !RST && (w_lwstall || w_brstall || w_mdustall);
        w_flushd   = !RST && (hz.PCSRCD || hz.JMPD) && !w_stall;
    end

    always_comb begin
        hz.FORWARDAE = 2'b00;
        hz.FORWARDBE = 2'b00;
        hz.FORWARDAD = 1'b0;
        hz.FORWARDBD = 1'b0;
        if (!RST) begin
            if (hit(hz.WREGM, hz.WRITEREGM, hz.RSE))      hz.FORWARDAE = 2'b10;
            else if (hit(hz.WREGW, hz.WRITEREGW, hz.RSE)) hz.FORWARDAE = 2'b01;
            if (hit(hz.WREGM, hz.WRITEREGM, hz.RTE))      hz.FORWARDBE = 2'b10;
            else if (hit(hz.WREGW, hz.WRITEREGW, hz.RTE)) hz.FORWARDBE = 2'b01;
            hz.FORWARDAD = hit(hz.WREGM, hz.WRITEREGM, hz.RSD);
            hz.FORWARDBD = hit(hz.WREGM, hz.WRITEREGM, hz.RTD);
        end
    end

    assign hz.STALLF = w_stall;
    assign hz.STALLD = w_stall;
    assign hz.FLUSHE = w_stall;
    assign hz.FLUSHD = w_flushd;

    // MDU sequencer: an issue while running is ignored rather than reloading the count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (hz.MDUSTARTE) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = LAT8;
                end
            end
            S_RUN: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign hz.MDUBUSY = w_busy;
    assign hz.MDUDONE = w_done && !RST;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stallcnt, r_flushcnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stallcnt <= 32'd0;
            r_flushcnt <= 32'd0;
        end else begin
            if (w_stall)  r_stallcnt <= r_stallcnt + 32'd1;
            if (w_flushd) r_flushcnt <= r_flushcnt + 32'd1;
        end
    end

    assign w_stallcnt = RST ? 32'd0 : r_stallcnt;
    assign w_flushcnt = RST ? 32'd0 : r_flushcnt;
`else
    assign w_stallcnt = 32'd0;
    assign w_flushcnt = 32'd0;
`endif

    assign hz.STALLCNT = w_stallcnt;
    assign hz.FLUSHCNT = w_flushcnt;
endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: one instance with MDU_LAT=4, one with MDU_LAT=32 for the reset-abort case.
module tb_hazard_sched;
    logic clk = 1'b0;
    logic rsta, rstb;
    int   n_chk = 0;
    int   n_err = 0;
    bit   done_run = 1'b0;

    always #5 clk = ~clk;

    hazard_sched_if ha ();
    hazard_sched_if hb ();

    hazard_sched #(.MDU_LAT(4))  u_dut_a (.CLK(clk), .RST(rsta), .hz(ha));
    hazard_sched #(.MDU_LAT(32)) u_dut_b (.CLK(clk), .RST(rstb), .hz(hb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        ha.RSD = 0; ha.RTD = 0; ha.RSE = 0; ha.RTE = 0;
        ha.BRANCHD = 0; ha.PCSRCD = 0; ha.JMPD = 0; ha.MDUSTARTD = 0; ha.MDUREADD = 0;
        ha.WRITEREGE = 0; ha.WRITEREGM = 0; ha.WRITEREGW = 0;
        ha.WREGE = 0; ha.M2REGE = 0; ha.MDUSTARTE = 0; ha.WREGM = 0; ha.M2REGM = 0; ha.WREGW = 0;
    endtask

    task automatic clr_b();
        hb.RSD = 0; hb.RTD = 0; hb.RSE = 0; hb.RTE = 0;
        hb.BRANCHD = 0; hb.PCSRCD = 0; hb.JMPD = 0; hb.MDUSTARTD = 0; hb.MDUREADD = 0;
        hb.WRITEREGE = 0; hb.WRITEREGM = 0; hb.WRITEREGW = 0;
        hb.WREGE = 0; hb.M2REGE = 0; hb.MDUSTARTE = 0; hb.WREGM = 0; hb.M2REGM = 0; hb.WREGW = 0;
    endtask

    // An issue into a running MDU is a scheduling error in the surrounding pipeline.
    always @(negedge clk) begin
        if (!done_run) begin
            chk("issue_while_busy_a", 32'(ha.MDUSTARTE & ha.MDUBUSY), 32'd0);
            chk("issue_while_busy_b", 32'(hb.MDUSTARTE & hb.MDUBUSY), 32'd0);
        end
    end

    initial begin
        int nb, nd, dk;
        logic [31:0] exp_sc, exp_fc;
        clr_a();
        clr_b();
        rsta = 1'b1;
        rstb = 1'b1;
        // Hazardous inputs during reset must still give all-zero outputs.
        ha.WREGM = 1; ha.WRITEREGM = 8; ha.RSE = 8; ha.RSD = 8;
        ha.M2REGE = 1; ha.WREGE = 1; ha.WRITEREGE = 8; ha.PCSRCD = 1;
        cyc(); cyc();
        #1;
        chk("rst_fwdae", 32'(ha.FORWARDAE), 32'd0);
        chk("rst_fwdad", 32'(ha.FORWARDAD), 32'd0);
        chk("rst_stallf", 32'(ha.STALLF), 32'd0);
        chk("rst_flushd", 32'(ha.FLUSHD), 32'd0);
        chk("rst_busy", 32'(ha.MDUBUSY), 32'd0);
        chk("rst_stallcnt", ha.STALLCNT, 32'd0);
        clr_a();
        cyc();
        rsta = 1'b0;
        rstb = 1'b0;

        // Forwarding priority and r0 exclusion
        ha.WREGM = 1; ha.WRITEREGM = 8; ha.WREGW = 1; ha.WRITEREGW = 8; ha.RSE = 8;
        #1 chk("fwdae_m_prio", 32'(ha.FORWARDAE), 32'd2);
        ha.RSE = 0;
        #1 chk("fwdae_r0", 32'(ha.FORWARDAE), 32'd0);
        ha.RSE = 8; ha.WREGM = 0;
        #1 chk("fwdae_w", 32'(ha.FORWARDAE), 32'd1);
        ha.RTE = 8;
        #1 chk("fwdbe_w", 32'(ha.FORWARDBE), 32'd1);
        ha.WREGM = 1; ha.RTE = 9;
        #1 chk("fwdbe_none", 32'(ha.FORWARDBE), 32'd0);
        ha.RSD = 8; ha.RTD = 8;
        #1 chk("fwdad", 32'(ha.FORWARDAD), 32'd1);
        chk("fwdbd", 32'(ha.FORWARDBD), 32'd1);
        ha.WRITEREGM = 0; ha.RSD = 0;
        #1 chk("fwdad_r0", 32'(ha.FORWARDAD), 32'd0);
        clr_a();

        // Load-use: stall one cycle, clear once the load reaches M
        cyc();
        ha.M2REGE = 1; ha.WREGE = 1; ha.WRITEREGE = 5; ha.RSD = 5;
        #1 chk("lw_stallf", 32'(ha.STALLF), 32'd1);
        chk("lw_stalld", 32'(ha.STALLD), 32'd1);
        chk("lw_flushe", 32'(ha.FLUSHE), 32'd1);
        cyc();
        ha.M2REGE = 0; ha.WREGE = 0; ha.WRITEREGE = 0;
        ha.M2REGM = 1; ha.WREGM = 1; ha.WRITEREGM = 5;
        #1 chk("lw_clear", 32'(ha.STALLF), 32'd0);
        clr_a();

        // Branch waiting on a load in M must not flush
        cyc();
        ha.BRANCHD = 1; ha.RTD = 3; ha.M2REGM = 1; ha.WRITEREGM = 3; ha.PCSRCD = 1;
        #1 chk("br_stall", 32'(ha.STALLD), 32'd1);
        chk("br_noflush", 32'(ha.FLUSHD), 32'd0);
        cyc();
        ha.M2REGM = 0; ha.WRITEREGM = 0;
        #1 chk("br_flush", 32'(ha.FLUSHD), 32'd1);
        chk("br_nostall", 32'(ha.STALLD), 32'd0);
        clr_a();
        ha.JMPD = 1;
        #1 chk("jmp_flush", 32'(ha.FLUSHD), 32'd1);
        clr_a();

        // MDU sequencing with MDU_LAT=4, mfhi held in D from the issue cycle
        cyc();
        ha.MDUSTARTE = 1; ha.MDUREADD = 1;
        #1 chk("mdu_t_stall", 32'(ha.STALLF), 32'd1);
        chk("mdu_t_busy", 32'(ha.MDUBUSY), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            ha.MDUSTARTE = 0;
            #1;
            chk($sformatf("mdu_busy_%0d", k), 32'(ha.MDUBUSY), (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("mdu_done_%0d", k), 32'(ha.MDUDONE), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("mdu_stall_%0d", k), 32'(ha.STALLD), (k <= 4) ? 32'd1 : 32'd0);
        end
        clr_a();

        // Performance counters: 3 load-use stalls, 2 taken branches after a fresh reset
        cyc();
        rsta = 1'b1;
        cyc();
        rsta = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ha.M2REGE = 1; ha.WREGE = 1; ha.WRITEREGE = 7; ha.RTD = 7;
            cyc();
            clr_a();
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            ha.BRANCHD = 1; ha.PCSRCD = 1; ha.RSD = 4;
            cyc();
            clr_a();
            cyc();
        end
`ifdef HAZ_PERF_CNT_EN
        exp_sc = 32'd3;
        exp_fc = 32'd2;
`else
        exp_sc = 32'd0;
        exp_fc = 32'd0;
`endif
        #1 chk("stallcnt", ha.STALLCNT, exp_sc);
        chk("flushcnt", ha.FLUSHCNT, exp_fc);

        // MDU_LAT=32 run aborted by reset ten cycles after issue
        hb.MDUSTARTE = 1;
        cyc();
        hb.MDUSTARTE = 0;
        #1 chk("b_busy_1", 32'(hb.MDUBUSY), 32'd1);
        for (int k = 2; k <= 10; k++) cyc();
        #1 chk("b_busy_10", 32'(hb.MDUBUSY), 32'd1);
        rstb = 1'b1;
        cyc();
        rstb = 1'b0;
        #1 chk("b_abort_busy", 32'(hb.MDUBUSY), 32'd0);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (hb.MDUDONE) nd++;
            cyc();
        end
        chk("b_abort_nodone", 32'(nd), 32'd0);

        // Fresh issue after reset gives the full window
        hb.MDUSTARTE = 1;
        cyc();
        hb.MDUSTARTE = 0;
        nb = 0; nd = 0; dk = 0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (hb.MDUBUSY) nb++;
            if (hb.MDUDONE) begin
                nd++;
                dk = k;
            end
            cyc();
        end
        chk("b_busy_cycles", 32'(nb), 32'd32);
        chk("b_done_count", 32'(nd), 32'd1);
        chk("b_done_cycle", 32'(dk), 32'd32);

        done_run = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
Pipeline hazard scheduler for the 5-stage MIPS core.
- Generates the forwarding selects for the D-stage branch comparator and the E-stage ALU.
- Generates load-use stalls and branch-operand stalls, plus fetch/decode stalls and E/D flushes.
- Sequences a multi-cycle mult/div unit (MDU) with a busy state machine, holding dependent instructions in D.
- Sits beside the per-stage decoders; consumes their WREG/M2REG/BRANCH/JMP outputs.

Parameters:
MDU_LAT, 32, cycles the MDU is busy after issue (legal range 1..255).

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
RSD  in  5  rs of D-stage instruction
RTD  in  5  rt of D-stage instruction
BRANCHD  in  1  D instruction is beq/bne
PCSRCD  in  1  D-stage branch taken
JMPD  in  1  D instruction is j
MDUSTARTD  in  1  D instruction is mult/div
MDUREADD  in  1  D instruction is mfhi/mflo
RSE  in  5  rs of E-stage instruction
RTE  in  5  rt of E-stage instruction
WRITEREGE  in  5  destination register, E stage
WREGE  in  1  E writes a register
M2REGE  in  1  E is a load
MDUSTARTE  in  1  mult/div is in E this cycle (issue)
WRITEREGM  in  5  destination register, M stage
WREGM  in  1  M writes a register
M2REGM  in  1  M is a load
WRITEREGW  in  5  destination register, W stage
WREGW  in  1  W writes a register
FORWARDAD  out  1  D comparator A takes the M result
FORWARDBD  out  1  D comparator B takes the M result
FORWARDAE  out  2  E src A select: 00 = regfile, 01 = W, 10 = M
FORWARDBE  out  2  E src B select, same encoding
STALLF  out  1  hold PC
STALLD  out  1  hold IF/ID
FLUSHD  out  1  clear IF/ID
FLUSHE  out  1  clear ID/EX (insert bubble)
MDUBUSY  out  1  MDU occupied
MDUDONE  out  1  one-cycle pulse at MDU completion
STALLCNT  out  32  stall-cycle counter (optional feature)
FLUSHCNT  out  32  D-flush counter (optional feature)

Behaviour:
General
- Register 0 never matches: every compare below also requires the source register != 0.
- All outputs are 0 while RST is high.

Forwarding (combinational)
- FORWARDAE = 10 if WREGM and WRITEREGM == RSE; else 01 if WREGW and WRITEREGW == RSE; else 00.
- FORWARDBE is the same using RTE.
- M has priority over W.
- FORWARDAD = WREGM and WRITEREGM == RSD. FORWARDBD uses RTD.

Stall terms (combinational)
- lwstall = M2REGE and WREGE and WRITEREGE in {RSD, RTD}.
- brstall = BRANCHD and ((WREGE and WRITEREGE in {RSD, RTD}) or (M2REGM and WRITEREGM in {RSD, RTD})).
- mdustall = (MDUSTARTD or MDUREADD) and (MDUBUSY or MDUSTARTE).
  - Covers back-to-back issue and an mfhi/mflo directly behind a mult.
- stall = lwstall or brstall or mdustall.
- STALLF = STALLD = FLUSHE = stall.
- FLUSHD = (PCSRCD or JMPD) and not stall. A stalled branch/jump does not flush.

MDU state machine (registered)
- States: IDLE, RUN. Counter cnt is 8 bits.
- IDLE: MDUSTARTE → RUN, cnt <= MDU_LAT.
- RUN: cnt <= cnt - 1 each cycle. When cnt == 1: → IDLE, cnt <= 0, MDUDONE = 1 for that cycle.
- MDUBUSY = (state == RUN).
  - High for exactly MDU_LAT cycles, starting the cycle after MDUSTARTE.
- MDUSTARTE while in RUN cannot occur (mdustall prevents it). If it does, it is ignored and the counter is not reloaded; the bench flags it as an error.
- RST in any state: → IDLE, cnt = 0, MDUBUSY = 0, MDUDONE = 0, same cycle edge.
  - A run aborted by reset produces no MDUDONE.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined:
  - STALLCNT increments on every cycle with stall = 1.
  - FLUSHCNT increments on every cycle with FLUSHD = 1.
  - Both wrap at 2^32, clear on RST, and update on the edge after the event.
- Not defined: both ports remain, are tied to 0, and no counter flops are built.

Test Plan:
- Load-use: E lw with WRITEREGE = 5, M2REGE = 1, WREGE = 1; D has RSD = 5 → STALLF = STALLD = FLUSHE = 1 for one cycle. Next cycle the lw is in M (M2REGE = 0) → stall = 0.
- Forward priority: WREGM = 1, WRITEREGM = 8; WREGW = 1, WRITEREGW = 8; RSE = 8 → FORWARDAE = 10. Then RSE = 0 → FORWARDAE = 00.
- Branch hazard: BRANCHD = 1, RTD = 3, M2REGM = 1, WRITEREGM = 3 → stall = 1 and FLUSHD = 0 even with PCSRCD = 1. Next cycle, dependency gone, PCSRCD = 1 → FLUSHD = 1, stall = 0.
- MDU sequencing, MDU_LAT = 4: MDUSTARTE pulse at cycle t → MDUBUSY high cycles t+1..t+4, MDUDONE at t+4. MDUREADD held from t → stall = 1 for cycles t..t+4, 0 at t+5.
- Reset mid-run: MDU_LAT = 32; assert RST 10 cycles after issue → next edge MDUBUSY = 0, no MDUDONE. A fresh MDUSTARTE after RST is released gives a full 32-cycle busy window.
- With HAZ_PERF_CNT_EN: 3 load-use stalls plus 2 taken branches → STALLCNT = 3, FLUSHCNT = 2. Without the macro, both read 0.
